pll_lock_reset_seq: RTL

//  Sits on the PLL wrapper's refclk side: drives the PLL's rst, qualifies its raw `locked`, and

---
 rtl/pll_seq_pkg.sv | 24 ++
 rtl/pll_lock_reset_seq_sync_2ff.sv | 34 +++
 rtl/pll_lock_reset_seq.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock / reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        QUALIFY   = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4
    } pll_seq_state_t;

    localparam int STAT_W = 8;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Two-flop synchronizer, reset to zero.
// Latency: 2 clk cycles from d to q. No backpressure.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_lock_reset_seq.sv
// PLL reset / lock qualification and staggered per-domain reset release on refclk.
// Latency: release 2+LOCK_STABLE_CYCLES after lock; lock loss reacts on the edge locked_s drops.
// Backpressure: none. Lock/timeout statistics built only when PLL_SEQ_STATS_EN is defined.
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS         = 5,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 4096,
    parameter int LOCK_TIMEOUT_CYCLES = 742500,
    parameter int STAGGER_CYCLES      = 64
) (
    input  logic                   refclk,
    input  logic                   rst,
    input  logic                   pll_locked_async,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst,
    output logic                   ready,
    output logic [STAT_W-1:0]      lock_loss_count,
    output logic [STAT_W-1:0]      timeout_count,
    output logic [2:0]             state_dbg
);

    localparam int PH_MAX = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int ST_W   = $clog2(STAGGER_CYCLES + 1);
    localparam int IX_W   = $clog2(NUM_DOMAINS + 1);

    localparam logic [PH_W-1:0] RST_LIM = PH_W'(PLL_RST_CYCLES);
    localparam logic [PH_W-1:0] STB_LIM = PH_W'(LOCK_STABLE_CYCLES);
    localparam logic [PH_W-1:0] TO_LIM  = PH_W'(LOCK_TIMEOUT_CYCLES);
    localparam logic [ST_W-1:0] STG_LIM = ST_W'(STAGGER_CYCLES);
    localparam logic [IX_W-1:0] IDX_END = IX_W'(NUM_DOMAINS);

    logic locked_s;

    pll_seq_state_t         state_q, state_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [ST_W-1:0]        stag_q, stag_d;
    logic [IX_W-1:0]        idx_q, idx_d;
    logic                   pll_rst_q, pll_rst_d;
    logic [NUM_DOMAINS-1:0] dom_rst_q, dom_rst_d;
    logic                   ready_q, ready_d;

    logic [PH_W-1:0]        phase_inc;
    logic [ST_W-1:0]        stag_inc;

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (refclk),
        .rst (rst),
        .d   (pll_locked_async),
        .q   (locked_s)
    );

    assign phase_inc = phase_q + 1'b1;
    assign stag_inc  = stag_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        stag_d    = stag_q;
        idx_d     = idx_q;
        dom_rst_d = dom_rst_q;
        ready_d   = ready_q;

        case (state_q)
            PLL_RST: begin
                dom_rst_d = '1;
                ready_d   = 1'b0;
                if (phase_inc == RST_LIM) begin
                    state_d = WAIT_LOCK;
                    phase_d = '0;
                end else begin
                    phase_d = phase_inc;
                end
            end

            WAIT_LOCK: begin
                if (locked_s) begin
                    state_d = QUALIFY;
                    phase_d = '0;
                end else if (phase_inc == TO_LIM) begin
                    state_d = PLL_RST;
                    phase_d = '0;
                end else begin
                    phase_d = phase_inc;
                end
            end

            QUALIFY: begin
                // A glitch is not a loss: the PLL gets another full timeout window.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    phase_d = '0;
                end else if (phase_inc == STB_LIM) begin
                    state_d      = RELEASE;
                    phase_d      = '0;
                    dom_rst_d[0] = 1'b0;
                    stag_d       = '0;
                    idx_d        = IX_W'(1);
                end else begin
                    phase_d = phase_inc;
                end
            end

            RELEASE: begin
                if (!locked_s) begin
                    state_d   = PLL_RST;
                    phase_d   = '0;
                    stag_d    = '0;
                    idx_d     = '0;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                end else if (stag_inc == STG_LIM) begin
                    stag_d = '0;
                    if (idx_q == IDX_END) begin
                        state_d = RUN;
                        ready_d = 1'b1;
                    end else begin
                        for (int i = 0; i < NUM_DOMAINS; i++) begin
                            if (idx_q == IX_W'(i)) begin
                                dom_rst_d[i] = 1'b0;
                            end
                        end
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    stag_d = stag_inc;
                end
            end

            RUN: begin
                if (!locked_s) begin
                    state_d   = PLL_RST;
                    phase_d   = '0;
                    stag_d    = '0;
                    idx_d     = '0;
                    dom_rst_d = '1;
                    ready_d   = 1'b0;
                end
            end

            default: begin
                state_d   = PLL_RST;
                phase_d   = '0;
                stag_d    = '0;
                idx_d     = '0;
                dom_rst_d = '1;
                ready_d   = 1'b0;
            end
        endcase

        // Registered so the PLL rst pin never sees state-decode glitches.
        pll_rst_d = (state_d == PLL_RST);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= PLL_RST;
            phase_q   <= '0;
            stag_q    <= '0;
            idx_q     <= '0;
            pll_rst_q <= 1'b1;
            dom_rst_q <= '1;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            phase_q   <= phase_d;
            stag_q    <= stag_d;
            idx_q     <= idx_d;
            pll_rst_q <= pll_rst_d;
            dom_rst_q <= dom_rst_d;
            ready_q   <= ready_d;
        end
    end

`ifdef PLL_SEQ_STATS_EN
    logic              loss_evt;
    logic              to_evt;
    logic [STAT_W-1:0] loss_cnt_q, loss_cnt_d;
    logic [STAT_W-1:0] to_cnt_q, to_cnt_d;

    assign loss_evt = ((state_q == RELEASE) || (state_q == RUN)) && !locked_s;
    assign to_evt   = (state_q == WAIT_LOCK) && !locked_s && (phase_inc == TO_LIM);

    always_comb begin
        loss_cnt_d = loss_evt ? sat_inc(loss_cnt_q) : loss_cnt_q;
        to_cnt_d   = to_evt ? sat_inc(to_cnt_q) : to_cnt_q;
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            loss_cnt_q <= '0;
            to_cnt_q   <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign lock_loss_count = loss_cnt_q;
    assign timeout_count   = to_cnt_q;
`else
    assign lock_loss_count = '0;
    assign timeout_count   = '0;
`endif

    assign pll_rst    = pll_rst_q;
    assign domain_rst = dom_rst_q;
    assign ready      = ready_q;
    assign state_dbg  = state_q;

endmodule
